// File: rtl/regfile_access_ctrl.sv
// Host command initiator for the 8x8 register file.
// Serves write, read, clear-all and dump-all requests with valid/ready handshakes.
module regfile_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_read_port_1,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output logic [ADDR_W-1:0] rf_write_port_1,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable
);

    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD, RSP, CLR, DRD, DRSP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   idx_nxt;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wport_q, wport_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rport_q, rport_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rlast_q, rlast_d;

    assign idx_nxt = idx_q + 1'b1;

    assign cmd_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign rsp_valid       = rvalid_q;
    assign rsp_addr        = raddr_q;
    assign rsp_data        = rdata_q;
    assign rsp_last        = rlast_q;
    assign rf_read_port_1  = rport_q;
    assign rf_write_port_1 = wport_q;
    assign rf_write_data   = wdata_q;
    assign rf_write_enable = we_q;

    // Next-state and registered-output decode for every command sequence
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wport_d  = wport_q;
        wdata_d  = wdata_q;
        rport_d  = rport_q;
        rvalid_d = rvalid_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        2'b00: begin
                            state_d = WR;
                            we_d    = 1'b1;
                            wport_d = cmd_addr;
                            wdata_d = cmd_wdata;
                        end
                        2'b01: begin
                            state_d = RD;
                            rport_d = cmd_addr;
                        end
                        2'b10: begin
                            state_d = CLR;
                            we_d    = 1'b1;
                            wport_d = '0;
                            wdata_d = '0;
                            idx_d   = '0;
                        end
                        default: begin
                            state_d = DRD;
                            rport_d = '0;
                            idx_d   = '0;
                        end
                    endcase
                end
            end
            WR: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
            RD: begin
                rdata_d  = rf_read_data_1;
                raddr_d  = rport_q;
                rlast_d  = 1'b1;
                rvalid_d = 1'b1;
                state_d  = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            CLR: begin
                if (idx_q == LAST) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_nxt;
                    wport_d = idx_nxt[ADDR_W-1:0];
                end
            end
            DRD: begin
                rdata_d  = rf_read_data_1;
                raddr_d  = idx_q[ADDR_W-1:0];
                rlast_d  = (idx_q == LAST);
                rvalid_d = 1'b1;
                state_d  = DRSP;
            end
            DRSP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_nxt;
                        rport_d = idx_nxt[ADDR_W-1:0];
                        state_d = DRD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wport_q  <= '0;
            wdata_q  <= '0;
            rport_q  <= '0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            wport_q  <= wport_d;
            wdata_q  <= wdata_d;
            rport_q  <= rport_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
        end
    end

endmodule
